// File: rtl/alu_seq_muldiv_pkg.sv
// rtl/alu_seq_muldiv_pkg.sv - opcodes, FSM states and shared types for the 8051 sequential ALU
package alu_seq_muldiv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_ADDC = 4'd1,
      ALU_SUBB = 4'd2,
      ALU_ANL  = 4'd3,
      ALU_ORL  = 4'd4,
      ALU_XRL  = 4'd5,
      ALU_INC  = 4'd6,
      ALU_DEC  = 4'd7,
      ALU_CPL  = 4'd8,
      ALU_RL   = 4'd9,
      ALU_RR   = 4'd10,
      ALU_RLC  = 4'd11,
      ALU_RRC  = 4'd12,
      ALU_MUL  = 4'd13,
      ALU_DIV  = 4'd14,
      ALU_DA   = 4'd15
   } alu_op_e;

   typedef enum logic {
      ALU_ST_IDLE = 1'b0,
      ALU_ST_RUN  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// rtl/alu_seq_muldiv_if.sv - start/busy/done operand and result bundle of the sequential ALU
interface alu_seq_muldiv_if #(parameter int WIDTH = 8);
   logic             start;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             carry_in;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             psw_c;
   logic             psw_ac;
   logic             psw_ov;
   logic             busy;
   logic             done;

   modport master (
      output start, alu_op, operand1, operand2, carry_in,
      input  result_lo, result_hi, psw_c, psw_ac, psw_ov, busy, done
   );

   modport slave (
      input  start, alu_op, operand1, operand2, carry_in,
      output result_lo, result_hi, psw_c, psw_ac, psw_ov, busy, done
   );
endinterface

// File: rtl/alu_shift_muldiv.sv
// rtl/alu_shift_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_shift_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic             div_o,
   output logic [WIDTH-1:0] nxt_hi_o,
   output logic [WIDTH-1:0] nxt_lo_o
);
   localparam int CW = $clog2(WIDTH + 1);

   // hi_q: partial product / remainder; lo_q: multiplier / dividend-then-quotient
   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic             div_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic             div_ge;

   // One iteration of whichever operation is loaded
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_sh   = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      // remainder < divisor keeps div_sh < 2*divisor, so the top bit is a clean sign
      div_ge   = ~div_diff[WIDTH];
      if (div_q) begin
         nxt_hi_o = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         nxt_lo_o = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         nxt_hi_o = mul_sum[WIDTH:1];
         nxt_lo_o = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   assign last_o = (cnt_q == CW'(WIDTH - 1));
   assign div_o  = div_q;

   // Capture operands on launch, then advance one bit per step
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (load_i) begin
         hi_q  <= '0;
         lo_q  <= a_i;
         b_q   <= b_i;
         div_q <= is_div_i;
         cnt_q <= '0;
      end else if (step_i) begin
         hi_q  <= nxt_hi_o;
         lo_q  <= nxt_lo_o;
         cnt_q <= cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - 8051 accumulator ALU with sequential MUL/DIV; ALU_DA_EN enables decimal adjust
module alu_seq_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic            clock_i,
   input  logic            reset_ni,
   alu_seq_muldiv_if.slave bus
);
   import alu_seq_muldiv_pkg::*;

   alu_state_e       state_q, state_d;
   alu_op_e          op;
   logic [WIDTH-1:0] a, b;
   logic             cin_add;

   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
   logic             c_q, c_d, ac_q, ac_d, ov_q, ov_d, done_q, done_d;

   logic [WIDTH:0]   add_full, sub_full;
   logic [WIDTH-1:0] alu_lo;
   logic             alu_c, alu_ac, alu_ov;

   logic             md_load, md_step, md_last, md_div;
   logic [WIDTH-1:0] md_hi, md_lo;

   assign op      = alu_op_e'(bus.alu_op);
   assign a       = bus.operand1;
   assign b       = bus.operand2;
   assign cin_add = (op == ALU_ADDC) & bus.carry_in;

   alu_shift_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .load_i   (md_load),
      .step_i   (md_step),
      .is_div_i (op == ALU_DIV),
      .a_i      (a),
      .b_i      (b),
      .last_o   (md_last),
      .div_o    (md_div),
      .nxt_hi_o (md_hi),
      .nxt_lo_o (md_lo)
   );

`ifdef ALU_DA_EN
   logic [8:0]       da1, da2;
   logic [WIDTH-1:0] da_lo;
   logic             da_c;

   // Decimal adjust on the low byte; AC comes from the last registered flag, CY only ever sets
   always_comb begin
      da1   = (a[3:0] > 4'd9 || ac_q) ? {1'b0, a[7:0]} + 9'h006 : {1'b0, a[7:0]};
      da2   = (da1[7:4] > 4'd9 || bus.carry_in || da1[8]) ? {1'b0, da1[7:0]} + 9'h060
                                                          : {1'b0, da1[7:0]};
      da_lo = a;
      da_lo[7:0] = da2[7:0];
      da_c  = bus.carry_in | da1[8] | da2[8];
   end
`endif

   // Single-cycle datapath; carries into a bit are recovered as sum ^ a ^ b at that bit
   always_comb begin
      add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_add};
      sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bus.carry_in};
      alu_lo   = a;
      alu_c    = c_q;
      alu_ac   = ac_q;
      alu_ov   = ov_q;
      case (op)
         ALU_ADD, ALU_ADDC: begin
            alu_lo = add_full[WIDTH-1:0];
            alu_c  = add_full[WIDTH];
            alu_ac = add_full[4] ^ a[4] ^ b[4];
            alu_ov = (add_full[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1]) ^ add_full[WIDTH];
         end
         ALU_SUBB: begin
            alu_lo = sub_full[WIDTH-1:0];
            alu_c  = sub_full[WIDTH];
            alu_ac = sub_full[4] ^ a[4] ^ b[4];
            alu_ov = (a[WIDTH-1] ^ b[WIDTH-1]) & (sub_full[WIDTH-1] ^ a[WIDTH-1]);
         end
         ALU_ANL: alu_lo = a & b;
         ALU_ORL: alu_lo = a | b;
         ALU_XRL: alu_lo = a ^ b;
         ALU_INC: alu_lo = a + {{(WIDTH-1){1'b0}}, 1'b1};
         ALU_DEC: alu_lo = a - {{(WIDTH-1){1'b0}}, 1'b1};
         ALU_CPL: alu_lo = ~a;
         ALU_RL:  alu_lo = {a[WIDTH-2:0], a[WIDTH-1]};
         ALU_RR:  alu_lo = {a[0], a[WIDTH-1:1]};
         ALU_RLC: begin
            alu_lo = {a[WIDTH-2:0], bus.carry_in};
            alu_c  = a[WIDTH-1];
         end
         ALU_RRC: begin
            alu_lo = {bus.carry_in, a[WIDTH-1:1]};
            alu_c  = a[0];
         end
         ALU_DA: begin
`ifdef ALU_DA_EN
            alu_lo = da_lo;
            alu_c  = da_c;
`else
            alu_lo = a;
`endif
         end
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= ALU_ST_IDLE;
      else           state_q <= state_d;
   end

   // FSM next state: only a non-zero MUL/DIV operand2 needs the iterative path
   always_comb begin
      state_d = state_q;
      case (state_q)
         ALU_ST_IDLE: if (bus.start && (op == ALU_MUL || op == ALU_DIV) && b != '0)
                         state_d = ALU_ST_RUN;
         ALU_ST_RUN:  if (md_last) state_d = ALU_ST_IDLE;
         default:     state_d = ALU_ST_IDLE;
      endcase
   end

   // FSM outputs: next values of the result/flag registers and muldiv control
   always_comb begin
      lo_d    = lo_q;
      hi_d    = hi_q;
      c_d     = c_q;
      ac_d    = ac_q;
      ov_d    = ov_q;
      done_d  = 1'b0;
      md_load = 1'b0;
      md_step = 1'b0;
      if (state_q == ALU_ST_IDLE && bus.start) begin
         if (op == ALU_MUL || op == ALU_DIV) begin
            if (b != '0) begin
               md_load = 1'b1;
            end else begin
               lo_d   = (op == ALU_DIV) ? {WIDTH{1'b1}} : '0;
               hi_d   = (op == ALU_DIV) ? a : '0;
               c_d    = 1'b0;
               ov_d   = (op == ALU_DIV);
               done_d = 1'b1;
            end
         end else begin
            lo_d   = alu_lo;
            hi_d   = '0;
            c_d    = alu_c;
            ac_d   = alu_ac;
            ov_d   = alu_ov;
            done_d = 1'b1;
         end
      end else if (state_q == ALU_ST_RUN) begin
         md_step = 1'b1;
         if (md_last) begin
            lo_d   = md_lo;
            hi_d   = md_hi;
            c_d    = 1'b0;
            ov_d   = md_div ? 1'b0 : (md_hi != '0);
            done_d = 1'b1;
         end
      end
   end

   // Result and flag registers hold until the next completion
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         lo_q   <= '0;
         hi_q   <= '0;
         c_q    <= 1'b0;
         ac_q   <= 1'b0;
         ov_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         lo_q   <= lo_d;
         hi_q   <= hi_d;
         c_q    <= c_d;
         ac_q   <= ac_d;
         ov_q   <= ov_d;
         done_q <= done_d;
      end
   end

   assign bus.result_lo = lo_q;
   assign bus.result_hi = hi_q;
   assign bus.psw_c     = c_q;
   assign bus.psw_ac    = ac_q;
   assign bus.psw_ov    = ov_q;
   assign bus.busy      = (state_q == ALU_ST_RUN);
   assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb/tb_alu_seq_muldiv.sv - directed self-checking bench for alu_seq_muldiv (WIDTH=8)
module tb_alu_seq_muldiv;
   import alu_seq_muldiv_pkg::*;

   logic clock_i = 1'b0;
   logic reset_ni;
   int   errors = 0;
   int   checks = 0;

   always #5 clock_i = ~clock_i;

   alu_seq_muldiv_if #(.WIDTH(8)) bus ();
   alu_seq_muldiv #(.WIDTH(8)) dut (.clock_i(clock_i), .reset_ni(reset_ni), .bus(bus));

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] lo;
      logic       c;
   } vec_t;

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
      @(negedge clock_i);
      bus.start    = 1'b1;
      bus.alu_op   = op;
      bus.operand1 = a;
      bus.operand2 = b;
      bus.carry_in = cin;
      @(posedge clock_i);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input logic intrude, output int cycles, output logic got, output logic busy_ok);
      cycles  = 0;
      got     = 1'b0;
      busy_ok = 1'b1;
      while (!got && cycles < 20) begin
         if (intrude && cycles == 2) begin
            bus.start    = 1'b1;
            bus.alu_op   = ALU_ADD;
            bus.operand1 = 8'h01;
            bus.operand2 = 8'h01;
         end
         @(posedge clock_i);
         #1;
         bus.start = 1'b0;
         cycles++;
         if (bus.done) got = 1'b1;
         else if (!bus.busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset_ni     = 1'b0;
      bus.start    = 1'b0;
      bus.alu_op   = 4'd0;
      bus.operand1 = 8'h00;
      bus.operand2 = 8'h00;
      bus.carry_in = 1'b0;
      repeat (2) @(posedge clock_i);
      #1;
      checks++;
      if ({bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.busy, bus.done} !== 21'h0) begin
         errors++;
         $display("FAIL reset_state: got lo=%h hi=%h c/ac/ov=%b%b%b busy=%b done=%b, want all 0",
                  bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.busy, bus.done);
      end
      @(negedge clock_i);
      reset_ni = 1'b1;
   endtask

   task automatic test_add;
      drive(ALU_ADD, 8'h7F, 8'h01, 1'b0);
      checks++;
      if ({bus.result_lo, bus.result_hi, bus.done} !== {8'h80, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL add_result: got lo=%h hi=%h done=%b, want lo=80 hi=00 done=1", bus.result_lo, bus.result_hi, bus.done);
      end
      checks++;
      if ({bus.psw_c, bus.psw_ac, bus.psw_ov} !== 3'b011) begin
         errors++;
         $display("FAIL add_flags: got c/ac/ov=%b%b%b, want 011", bus.psw_c, bus.psw_ac, bus.psw_ov);
      end
      @(posedge clock_i);
      #1;
      checks++;
      if ({bus.done, bus.result_lo} !== {1'b0, 8'h80}) begin
         errors++;
         $display("FAIL add_hold: got done=%b lo=%h, want done=0 lo=80", bus.done, bus.result_lo);
      end
   endtask

   task automatic test_subb_anl;
      drive(ALU_SUBB, 8'h00, 8'h01, 1'b1);
      checks++;
      if ({bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done} !== {8'hFE, 3'b110, 1'b1}) begin
         errors++;
         $display("FAIL subb: got lo=%h c/ac/ov=%b%b%b done=%b, want lo=FE 110 done=1",
                  bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done);
      end
      drive(ALU_ANL, 8'hF0, 8'h3C, 1'b0);
      checks++;
      if ({bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done} !== {8'h30, 3'b110, 1'b1}) begin
         errors++;
         $display("FAIL anl_flags_hold: got lo=%h c/ac/ov=%b%b%b done=%b, want lo=30 110 done=1",
                  bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done);
      end
   endtask

   task automatic test_single_ops;
      vec_t v [11];
      v = '{
         '{ALU_ADDC, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1},
         '{ALU_RL,   8'h81, 8'h00, 1'b0, 8'h03, 1'b1},
         '{ALU_RLC,  8'h41, 8'h00, 1'b0, 8'h82, 1'b0},
         '{ALU_RR,   8'h01, 8'h00, 1'b0, 8'h80, 1'b0},
         '{ALU_RRC,  8'h01, 8'h00, 1'b1, 8'h80, 1'b1},
         '{ALU_CPL,  8'h5A, 8'h00, 1'b0, 8'hA5, 1'b1},
         '{ALU_INC,  8'hFF, 8'h00, 1'b0, 8'h00, 1'b1},
         '{ALU_DEC,  8'h00, 8'h00, 1'b0, 8'hFF, 1'b1},
         '{ALU_XRL,  8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b1},
         '{ALU_ORL,  8'h50, 8'h05, 1'b0, 8'h55, 1'b1},
         '{ALU_RRC,  8'h02, 8'h00, 1'b0, 8'h01, 1'b0}
      };
      for (int i = 0; i < 11; i++) begin
         drive(v[i].op, v[i].a, v[i].b, v[i].cin);
         checks++;
         if ({bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done} !==
             {v[i].lo, 8'h00, v[i].c, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_op[%0d] op=%0d: got lo=%h hi=%h c/ac/ov=%b%b%b done=%b, want lo=%h hi=00 c/ac/ov=%b10 done=1",
                     i, v[i].op, bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done, v[i].lo, v[i].c);
         end
      end
   endtask

   task automatic test_mul;
      int   cycles;
      logic got, busy_ok;
      drive(ALU_MUL, 8'h50, 8'hA0, 1'b1);
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
         errors++;
         $display("FAIL mul_launch: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
      end
      bus.operand1 = 8'hFF;
      bus.operand2 = 8'hFF;
      wait_done(1'b1, cycles, got, busy_ok);
      checks++;
      if (!got || cycles != 8 || !busy_ok) begin
         errors++;
         $display("FAIL mul_latency: got done_seen=%b cycles=%0d busy_held=%b, want 1 8 1", got, cycles, busy_ok);
      end
      checks++;
      if ({bus.result_hi, bus.result_lo, bus.busy} !== {16'h3200, 1'b0}) begin
         errors++;
         $display("FAIL mul_result: got hi=%h lo=%h busy=%b, want hi=32 lo=00 busy=0", bus.result_hi, bus.result_lo, bus.busy);
      end
      checks++;
      if ({bus.psw_c, bus.psw_ac, bus.psw_ov} !== 3'b011) begin
         errors++;
         $display("FAIL mul_flags: got c/ac/ov=%b%b%b, want 011", bus.psw_c, bus.psw_ac, bus.psw_ov);
      end
      @(posedge clock_i);
      #1;
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         errors++;
         $display("FAIL mul_ignored_start: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_div;
      int   cycles;
      logic got, busy_ok;
      drive(ALU_DIV, 8'hFB, 8'h12, 1'b1);
      wait_done(1'b0, cycles, got, busy_ok);
      checks++;
      if (!got || cycles != 8 || !busy_ok) begin
         errors++;
         $display("FAIL div_latency: got done_seen=%b cycles=%0d busy_held=%b, want 1 8 1", got, cycles, busy_ok);
      end
      checks++;
      if ({bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov} !== {8'h0D, 8'h11, 3'b010}) begin
         errors++;
         $display("FAIL div_result: got lo=%h hi=%h c/ac/ov=%b%b%b, want lo=0D hi=11 010",
                  bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov);
      end
      drive(ALU_DIV, 8'h55, 8'h00, 1'b1);
      checks++;
      if ({bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done, bus.busy} !==
          {8'hFF, 8'h55, 3'b011, 2'b10}) begin
         errors++;
         $display("FAIL div_by_zero: got lo=%h hi=%h c/ac/ov=%b%b%b done=%b busy=%b, want lo=FF hi=55 011 done=1 busy=0",
                  bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done, bus.busy);
      end
   endtask

   task automatic test_da;
      drive(ALU_ADD, 8'h56, 8'h67, 1'b0);
      checks++;
      if ({bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov} !== {8'hBD, 3'b001}) begin
         errors++;
         $display("FAIL da_pre_add: got lo=%h c/ac/ov=%b%b%b, want lo=BD 001", bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov);
      end
`ifdef ALU_DA_EN
      drive(ALU_DA, 8'hBD, 8'h00, 1'b0);
      checks++;
      if ({bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done} !== {8'h23, 8'h00, 3'b101, 1'b1}) begin
         errors++;
         $display("FAIL da_adjust: got lo=%h hi=%h c/ac/ov=%b%b%b done=%b, want lo=23 hi=00 101 done=1",
                  bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done);
      end
`else
      drive(ALU_DA, 8'hBD, 8'h00, 1'b1);
      checks++;
      if ({bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done} !== {8'hBD, 8'h00, 3'b001, 1'b1}) begin
         errors++;
         $display("FAIL da_noop: got lo=%h hi=%h c/ac/ov=%b%b%b done=%b, want lo=BD hi=00 001 done=1",
                  bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done);
      end
`endif
   endtask

   task automatic test_reset_mid_mul;
      logic saw_done;
      drive(ALU_MUL, 8'h50, 8'hA0, 1'b0);
      repeat (3) @(posedge clock_i);
      #3;
      reset_ni = 1'b0;
      #1;
      checks++;
      if ({bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.busy, bus.done} !== 21'h0) begin
         errors++;
         $display("FAIL reset_mid_mul: got lo=%h hi=%h c/ac/ov=%b%b%b busy=%b done=%b, want all 0",
                  bus.result_lo, bus.result_hi, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.busy, bus.done);
      end
      saw_done = 1'b0;
      repeat (2) begin
         @(posedge clock_i);
         #1;
         if (bus.done) saw_done = 1'b1;
      end
      @(negedge clock_i);
      reset_ni = 1'b1;
      repeat (10) begin
         @(posedge clock_i);
         #1;
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: got stray done/busy after reset=%b, want 0", saw_done);
      end
      drive(ALU_ADD, 8'h01, 8'h02, 1'b0);
      checks++;
      if ({bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done} !== {8'h03, 3'b000, 1'b1}) begin
         errors++;
         $display("FAIL add_after_reset: got lo=%h c/ac/ov=%b%b%b done=%b, want lo=03 000 done=1",
                  bus.result_lo, bus.psw_c, bus.psw_ac, bus.psw_ov, bus.done);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_subb_anl;
      test_single_ops;
      test_mul;
      test_div;
      test_da;
      test_reset_mid_mul;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
